bin_to_bcd_serial: RTL and testbench
====================================

# bin_to_bcd_serial

Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) that sits directly upstream of the four-digit seven-segment display driver. It accepts a binary count or score on a start strobe and, after a fixed latency, presents packed BCD digits plus a one-cycle done pulse. The display stage then selects digits by plain slicing instead of doing divide/modulo arithmetic. Values above the displayable range saturate to all nines and raise an overflow flag.

## Interface
- WIDTH, 14: binary input width in bits, ≥ 4.
- DIGITS, 4: number of BCD digits produced; must satisfy 10^DIGITS ≥ 2^WIDTH or saturation applies.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset, sampled on rising clk.
- start  in  1  request strobe; accepted only when busy=0.
- bin  in  WIDTH  unsigned binary value, sampled on the accepting edge only.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse; bcd/overflow updated on the same edge.
- bcd  out  4*DIGITS  packed result; bcd[4*DIGITS-1 -: 4] is the most significant digit (leftmost display digit), bcd[3:0] the least. Held stable between done pulses.
- overflow  out  1  set when the last accepted bin exceeded 10^DIGITS−1; held with bcd.

## Operation
- States are IDLE, SHIFT and DONE.
- IDLE:
  - busy=0.
  - If start=1: latch bin into a WIDTH-bit shift register, clear the 4*DIGITS-bit BCD scratch register, load the iteration counter with WIDTH, latch ovf_pending = (bin > 10^DIGITS−1), and go to SHIFT.
- SHIFT: each cycle does one iteration:
  - For every scratch digit ≥ 5, add 3 to that digit (all digits in parallel, 4-bit arithmetic).
  - Shift {scratch, binreg} left by 1.
  - Decrement the counter.
  - When the counter reaches 0 after this iteration, go to DONE.
- DONE, one cycle:
  - Load bcd with the scratch register, or with all digits 4'h9 if ovf_pending.
  - Load overflow = ovf_pending.
  - Assert done for this cycle only and return to IDLE.
- Iteration counter width is $clog2(WIDTH+1). The comparison constant 10^DIGITS−1 is computed at elaboration and needs no runtime multiply.
- start while busy=1 is ignored and not queued. bin changes while busy have no effect.
- Reset in any state:
  - state goes to IDLE; busy, done, overflow = 0; bcd = 0; scratch and counter cleared.
  - Any conversion in progress is abandoned and produces no done pulse.
- Reset and start asserted in the same cycle: reset wins; start is dropped.

## Timing
- Reset values: busy=0, done=0, bcd=0, overflow=0.
- Accepting edge k (IDLE, start=1): busy=1 from edge k.
- Shift iterations on edges k+1 … k+WIDTH (WIDTH iterations).
- Edge k+WIDTH+1 (DONE): bcd/overflow updated, done=1, busy=1 (DONE counts as busy).
- Edge k+WIDTH+2: done=0, busy=0, IDLE.
- Throughput: a new start is accepted while done is high only if the FSM is already in IDLE. Because DONE holds busy=1, the earliest next accept is the edge after done falls, giving a minimum period of WIDTH+2 cycles. With WIDTH=14, latency is 15 cycles from accept to done.
- Outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Reset: assert reset 3 cycles with start=1 and bin=1234.
  - Required: busy, done, overflow = 0 and bcd=16'h0000 throughout; no done after release.
- Nominal: bin=1234, start pulse at accept edge k.
  - Required: busy high edges k…k+15; done=1 exactly at edge k+15; bcd=16'h1234; overflow=0.
- Edges:
  - bin=0 → bcd=16'h0000.
  - bin=9999 → bcd=16'h9999, overflow=0.
  - bin=10 → bcd=16'h0010.
  - bin=5 → bcd=16'h0005.
- Saturation:
  - bin=12000 → bcd=16'h9999, overflow=1.
  - Then bin=42 → bcd=16'h0042, overflow=0.
- Handshake:
  - start held high continuously with bin=7 then bin=8 changed mid-conversion: first done gives 16'h0007.
  - Next accept happens on the cycle after done falls, sampling 8; done pulses every 16 cycles.
  - start pulses while busy produce no extra done.
- Reset mid-conversion:
  - bin=4321 accepted, then reset at edge k+6 for 1 cycle: no done; bcd=0.
  - Fresh start bin=4321 → 16'h4321 after 15 cycles.

Source files
------------

// File: rtl/bin_to_bcd_serial.sv
// Purpose : serial binary-to-BCD converter (shift-and-add-3, one bit per clock) feeding the display driver.
// Latency : WIDTH+1 cycles from the accepting edge to the done pulse; one conversion every WIDTH+2 cycles.
// Backpr. : start_i is honoured only in IDLE; starts while busy are dropped, never queued.
//
// Ports:
//   clk_i       system clock
//   reset_i     synchronous active-high reset
//   start_i     conversion request, sampled only while the FSM is idle
//   bin_i       unsigned binary value, sampled on the accepting edge
//   busy_o      high from the accepting edge through the done cycle
//   done_o      one-cycle pulse; bcd_o / overflow_o update on the same edge
//   bcd_o       packed BCD result, most significant digit in the top nibble
//   overflow_o  last accepted value did not fit in DIGITS decimal digits
module bin_to_bcd_serial #(
    parameter int WIDTH  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic [WIDTH-1:0]      bin_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic                  overflow_o
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    // Largest displayable value, folded to a constant at elaboration.
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    localparam logic [63:0] MAX_DEC = pow10(DIGITS) - 64'd1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] bin_q;
    logic [BW-1:0]    scratch_q;
    logic [CW-1:0]    cnt_q;
    logic             ovf_pending_q;
    logic             busy_q;
    logic             done_q;
    logic [BW-1:0]    bcd_q;
    logic             overflow_q;

    logic [BW-1:0]    adj;
    logic [BW-1:0]    scratch_d;
    logic [WIDTH-1:0] bin_d;

    // Add 3 to every digit that would reach 10 or more once doubled, so the
    // following shift carries correctly into the next decimal digit.
    always_comb begin
        adj = scratch_q;
        for (int d = 0; d < DIGITS; d++) begin
            if (scratch_q[4*d +: 4] >= 4'd5) begin
                adj[4*d +: 4] = scratch_q[4*d +: 4] + 4'd3;
            end
        end
    end

    // One step of the combined {scratch, binary} left shift.
    assign scratch_d = {adj[BW-2:0], bin_q[WIDTH-1]};
    assign bin_d     = {bin_q[WIDTH-2:0], 1'b0};

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            bin_q         <= '0;
            scratch_q     <= '0;
            cnt_q         <= '0;
            ovf_pending_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            bcd_q         <= '0;
            overflow_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        bin_q         <= bin_i;
                        scratch_q     <= '0;
                        cnt_q         <= CW'(WIDTH);
                        ovf_pending_q <= (64'(bin_i) > MAX_DEC);
                        busy_q        <= 1'b1;
                        state_q       <= SHIFT;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                SHIFT: begin
                    scratch_q <= scratch_d;
                    bin_q     <= bin_d;
                    cnt_q     <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    // busy_q stays high here; it drops on the following idle edge.
                    bcd_q      <= ovf_pending_q ? {DIGITS{4'h9}} : scratch_q;
                    overflow_q <= ovf_pending_q;
                    done_q     <= 1'b1;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign bcd_o      = bcd_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_bin_to_bcd_serial.sv
module tb_bin_to_bcd_serial;

    logic        clk;
    logic        reset;
    logic        start;
    logic [13:0] bin;
    logic        busy;
    logic        done;
    logic [15:0] bcd;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    bin_to_bcd_serial #(.WIDTH(14), .DIGITS(4)) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .start_i    (start),
        .bin_i      (bin),
        .busy_o     (busy),
        .done_o     (done),
        .bcd_o      (bcd),
        .overflow_o (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [13:0] bin;
        logic [15:0] exp_bcd;
        logic        exp_ovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Pulse start for one cycle with value v, then follow the conversion.
    // lat = cycles from the accepting edge to done (0 when no done pulse occurs),
    // busy_ok = busy high on every edge up to and including done,
    // tail = {done, busy} one edge after the done pulse.
    task automatic convert(input logic [13:0] v, output int lat, output logic busy_ok,
                           output logic [15:0] r_bcd, output logic r_ovf, output logic [1:0] tail);
        lat     = 0;
        busy_ok = 1'b1;
        r_bcd   = 'x;
        r_ovf   = 1'bx;
        tail    = 2'bxx;
        @(negedge clk);
        start = 1'b1;
        bin   = v;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (busy !== 1'b1) busy_ok = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (done === 1'b1) begin
                lat   = i;
                r_bcd = bcd;
                r_ovf = overflow;
                break;
            end
        end
        @(posedge clk);
        #1;
        tail = {done, busy};
    endtask

    vec_t        vecs[7];
    int          lat;
    logic        bok;
    logic [15:0] rb;
    logic        ro;
    logic [1:0]  tl;
    int          done_cnt;
    int          first_done;
    int          second_done;
    logic [15:0] first_bcd;
    logic [15:0] second_bcd;

    initial begin
        vecs[0] = '{14'd1234,  16'h1234, 1'b0};
        vecs[1] = '{14'd0,     16'h0000, 1'b0};
        vecs[2] = '{14'd9999,  16'h9999, 1'b0};
        vecs[3] = '{14'd10,    16'h0010, 1'b0};
        vecs[4] = '{14'd5,     16'h0005, 1'b0};
        vecs[5] = '{14'd12000, 16'h9999, 1'b1};
        vecs[6] = '{14'd42,    16'h0042, 1'b0};

        // Reset held with start asserted: everything stays at zero.
        reset = 1'b1;
        start = 1'b1;
        bin   = 14'd1234;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("reset_state_%0d", i), {12'd0, busy, done, overflow, bcd}, 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) done_cnt++;
        end
        check("reset_no_done", done_cnt, 0);
        check("reset_idle_state", {13'd0, busy, overflow, bcd}, 32'd0);

        // Table-driven conversions, including saturation and recovery.
        foreach (vecs[n]) begin
            convert(vecs[n].bin, lat, bok, rb, ro, tl);
            check($sformatf("latency_%0d", vecs[n].bin), lat, 15);
            check($sformatf("busy_%0d", vecs[n].bin), bok, 1);
            check($sformatf("bcd_%0d", vecs[n].bin), rb, vecs[n].exp_bcd);
            check($sformatf("ovf_%0d", vecs[n].bin), ro, vecs[n].exp_ovf);
            check($sformatf("tail_%0d", vecs[n].bin), tl, 2'b00);
        end

        // start held high; bin changes mid-conversion and is only picked up by the next accept.
        first_done  = 0;
        second_done = 0;
        first_bcd   = 'x;
        second_bcd  = 'x;
        @(negedge clk);
        start = 1'b1;
        bin   = 14'd7;
        @(posedge clk);
        #1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            #1;
            if (c == 3) bin = 14'd8;
            if (done === 1'b1) begin
                if (first_done == 0) begin
                    first_done = c;
                    first_bcd  = bcd;
                end else begin
                    second_done = c;
                    second_bcd  = bcd;
                    start = 1'b0;
                    break;
                end
            end
        end
        start = 1'b0;
        check("held_first_done_cycle", first_done, 15);
        check("held_first_bcd", first_bcd, 16'h0007);
        check("held_second_done_cycle", second_done, 31);
        check("held_second_bcd", second_bcd, 16'h0008);
        repeat (3) @(posedge clk);
        #1;
        check("held_idle_after", {done, busy}, 2'b00);

        // Start pulses while busy (including the done cycle) are dropped.
        @(negedge clk);
        start = 1'b1;
        bin   = 14'd100;
        @(posedge clk);
        #1;
        start = 1'b0;
        done_cnt = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) done_cnt++;
            start = (c == 3 || c == 7 || c == 14);
            bin   = 14'd555;
        end
        start = 1'b0;
        check("busy_pulses_done_count", done_cnt, 1);
        check("busy_pulses_bcd", bcd, 16'h0100);

        // Reset in the middle of a conversion abandons it.
        @(negedge clk);
        start = 1'b1;
        bin   = 14'd4321;
        @(posedge clk);
        #1;
        start = 1'b0;
        done_cnt = 0;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) done_cnt++;
            if (c == 6) check("midreset_cleared", {busy, overflow, bcd}, 18'd0);
            reset = (c == 5);
        end
        reset = 1'b0;
        check("midreset_no_done", done_cnt, 0);
        check("midreset_bcd_zero", bcd, 16'h0000);

        convert(14'd4321, lat, bok, rb, ro, tl);
        check("fresh_latency", lat, 15);
        check("fresh_bcd", rb, 16'h4321);
        check("fresh_ovf", ro, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
